rvv_backend_mul_rs_fifo: RTL and testbench

//  MUL reservation-station FIFO. Write side takes up to 2 MUL/MAC uops/cycle from dispatch.

---
 rtl/rvv_backend_mul_rs_fifo_pkg.sv | 21 ++
 rtl/rvv_backend_mul_rs_fifo_multi_fifo_2w2r.sv | 80 ++++++++
 rtl/rvv_backend_mul_rs_fifo.sv | 60 ++++++
 tb/tb_rvv_backend_mul_rs_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_mul_rs_fifo_pkg.sv
// Shared types and sizing for the MUL/MAC reservation-station slice.
package rvv_backend_mul_rs_fifo_pkg;

  localparam int NUM_MUL      = 2;
  localparam int MUL_RS_DEPTH = 8;

  typedef struct packed {
    logic [5:0]  rob_entry;
    logic [5:0]  uop_funct6;
    logic [2:0]  vd_eew;
    logic        vm;
    logic [31:0] vs1_data;
    logic [31:0] vs2_data;
  } MUL_RS_t;

  // Number of set bits in a 2-slot request vector.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rvv_backend_mul_rs_fifo_multi_fifo_2w2r.sv
// Generic 2-write / 2-read circular buffer with registered storage.
// Slot 0 is always the older entry on both the write and the read side.
module multi_fifo_2w2r
  import rvv_backend_mul_rs_fifo_pkg::*;
#(
  parameter type T           = logic [7:0],
  parameter int  DEPTH       = 8,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [1:0]       push_i,
  input  T     [1:0]       data_i,
  input  logic [1:0]       pop_i,
  output T     [1:0]       data_o,
  output logic [CNT_W-1:0] count_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptrNext1;
  logic [PTR_W-1:0] rptrNext1;
  logic [1:0]       nPush;
  logic [1:0]       nPop;

  assign nPush     = popcount2(push_i);
  assign nPop      = popcount2(pop_i);
  assign wptrNext1 = wptr_q + PTR_W'(1);
  assign rptrNext1 = rptr_q + PTR_W'(1);

  // Next pointer/occupancy: flush overrides every push and pop in the same cycle.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(nPush);
    rptr_d  = rptr_q + PTR_W'(nPop);
    count_d = count_q + CNT_W'(nPush) - CNT_W'(nPop);
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; popped entries are left in place, only new pushes overwrite.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush_i) begin
      if (push_i[0]) begin
        mem_q[wptr_q] <= data_i[0];
      end
      if (push_i[1]) begin
        mem_q[wptrNext1] <= data_i[1];
      end
    end
  end

  assign data_o[0] = mem_q[rptr_q];
  assign data_o[1] = mem_q[rptrNext1];
  assign count_o   = count_q;

endmodule

// File: rtl/rvv_backend_mul_rs_fifo.sv
// MUL reservation-station FIFO: 2 uops in from dispatch, 2 oldest out to the MUL/MAC wrapper.
// Status flags are decoded from the registered occupancy only.
module rvv_backend_mul_rs_fifo
  import rvv_backend_mul_rs_fifo_pkg::*;
#(
  parameter int  DEPTH = MUL_RS_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trap_flush_rvv,
  input  logic [NUM_MUL-1:0]        dp2rs_push,
  input  MUL_RS_t [NUM_MUL-1:0]     dp2rs_data,
  output logic                      rs2dp_full,
  output logic                      rs2dp_1left_to_full,
  output MUL_RS_t [NUM_MUL-1:0]     rs2ex_uop_data,
  output logic                      rs2ex_fifo_empty,
  output logic                      rs2ex_fifo_1left_to_empty,
  input  logic [NUM_MUL-1:0]        ex2rs_fifo_pop
);

  logic [CNT_W-1:0] count;
  logic [1:0]       nPush;
  logic [1:0]       nPop;

  multi_fifo_2w2r #(
    .T     (MUL_RS_t),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (trap_flush_rvv),
    .push_i  (dp2rs_push),
    .data_i  (dp2rs_data),
    .pop_i   (ex2rs_fifo_pop),
    .data_o  (rs2ex_uop_data),
    .count_o (count)
  );

  assign rs2dp_full                = (count == CNT_W'(DEPTH));
  assign rs2dp_1left_to_full       = (count >= CNT_W'(DEPTH - 1));
  assign rs2ex_fifo_empty          = (count == '0);
  assign rs2ex_fifo_1left_to_empty = (count <= CNT_W'(1));

  assign nPush = popcount2(dp2rs_push);
  assign nPop  = popcount2(ex2rs_fifo_pop);

  // Slot 1 may only be used together with slot 0, on both sides.
  aPushOrder: assert property (@(posedge clk) disable iff (!rst_n)
    !(dp2rs_push[1] && !dp2rs_push[0]));
  aPopOrder: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex2rs_fifo_pop[1] && !ex2rs_fifo_pop[0]));

  // Storage must never be overrun or read past the tail; a same-cycle pop releases the slots a push reuses.
  aNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) + int'(nPush) - int'(nPop)) <= DEPTH);
  aNoUnderflow: assert property (@(posedge clk) disable iff (!rst_n)
    int'(nPop) <= int'(count));

endmodule

// File: tb/tb_rvv_backend_mul_rs_fifo.sv
// Self-checking bench for the MUL reservation-station FIFO.
`timescale 1ns/1ps
module tb_rvv_backend_mul_rs_fifo;
  import rvv_backend_mul_rs_fifo_pkg::*;

  localparam int DEPTH = MUL_RS_DEPTH;

  typedef struct {
    logic [1:0] push;
    logic [1:0] pop;
    logic       expEmpty;
    logic       expOneLeftEmpty;
    logic       expFull;
    logic       expOneLeftFull;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  trapFlush = 1'b0;
  logic [1:0]            push = 2'b00;
  logic [1:0]            pop = 2'b00;
  MUL_RS_t [NUM_MUL-1:0] pushData = '0;
  logic                  full;
  logic                  oneLeftFull;
  logic                  empty;
  logic                  oneLeftEmpty;
  MUL_RS_t [NUM_MUL-1:0] uopData;

  MUL_RS_t modelQ[$];
  int      checks = 0;
  int      failures = 0;
  vec_t    vecs[$];

  always #5 clk = ~clk;

  rvv_backend_mul_rs_fifo #(.DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .trap_flush_rvv            (trapFlush),
    .dp2rs_push                (push),
    .dp2rs_data                (pushData),
    .rs2dp_full                (full),
    .rs2dp_1left_to_full       (oneLeftFull),
    .rs2ex_uop_data            (uopData),
    .rs2ex_fifo_empty          (empty),
    .rs2ex_fifo_1left_to_empty (oneLeftEmpty),
    .ex2rs_fifo_pop            (pop)
  );

  function automatic MUL_RS_t randUop();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[$bits(MUL_RS_t)-1:0];
  endfunction

  task automatic checkBits(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare flags and visible entries against the scoreboard queue.
  task automatic checkOutput(input string tag);
    int sz;
    sz = modelQ.size();
    checkBits({tag, " empty"}, 128'(empty), 128'(sz == 0));
    checkBits({tag, " 1left_to_empty"}, 128'(oneLeftEmpty), 128'(sz <= 1));
    checkBits({tag, " full"}, 128'(full), 128'(sz == DEPTH));
    checkBits({tag, " 1left_to_full"}, 128'(oneLeftFull), 128'(sz >= DEPTH - 1));
    if (sz >= 1) checkBits({tag, " data0"}, 128'(uopData[0]), 128'(modelQ[0]));
    if (sz >= 2) checkBits({tag, " data1"}, 128'(uopData[1]), 128'(modelQ[1]));
  endtask

  // Drive one cycle of stimulus, then update the scoreboard with what the cycle should do.
  task automatic applyStimulus(input logic [1:0] p, input logic [1:0] o, input logic f,
                               input MUL_RS_t d0, input MUL_RS_t d1);
    push = p;
    pop = o;
    trapFlush = f;
    pushData[0] = d0;
    pushData[1] = d1;
    @(posedge clk);
    #1;
    if (f) begin
      modelQ.delete();
    end else begin
      for (int k = 0; k < int'(o[0]) + int'(o[1]); k++) begin
        if (modelQ.size() > 0) void'(modelQ.pop_front());
      end
      if (p[0]) modelQ.push_back(d0);
      if (p[1]) modelQ.push_back(d1);
    end
    push = 2'b00;
    pop = 2'b00;
    trapFlush = 1'b0;
  endtask

  initial begin
    MUL_RS_t a, b, c, d, e;

    vecs.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in reset");
    checkBits("in reset data0", 128'(uopData[0]), 128'(0));
    checkBits("in reset data1", 128'(uopData[1]), 128'(0));
    rst_n = 1'b1;

    // Post-reset idle.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b00, 2'b00, 1'b0, randUop(), randUop());
      checkOutput("idle");
      checkBits("idle data0", 128'(uopData[0]), 128'(0));
      checkBits("idle data1", 128'(uopData[1]), 128'(0));
    end

    // Table: 2-push/1-pop, fill to full, push+pop at full, drain.
    for (int i = 0; i < vecs.size(); i++) begin
      a = randUop();
      b = randUop();
      applyStimulus(vecs[i].push, vecs[i].pop, 1'b0, a, b);
      checkOutput($sformatf("vec%0d", i));
      checkBits($sformatf("vec%0d tbl empty", i), 128'(empty), 128'(vecs[i].expEmpty));
      checkBits($sformatf("vec%0d tbl 1left_to_empty", i), 128'(oneLeftEmpty), 128'(vecs[i].expOneLeftEmpty));
      checkBits($sformatf("vec%0d tbl full", i), 128'(full), 128'(vecs[i].expFull));
      checkBits($sformatf("vec%0d tbl 1left_to_full", i), 128'(oneLeftFull), 128'(vecs[i].expOneLeftFull));
    end

    // Pointer wrap: both pointers sit at 4; move them to 7, then push across the end.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 2'b00, 1'b0, randUop(), randUop());
      checkOutput("wrap fill");
    end
    applyStimulus(2'b00, 2'b11, 1'b0, '0, '0);
    applyStimulus(2'b00, 2'b01, 1'b0, '0, '0);
    checkOutput("wrap drained");
    c = randUop();
    d = randUop();
    applyStimulus(2'b11, 2'b00, 1'b0, c, d);
    checkOutput("wrap push");
    checkBits("wrap C at head", 128'(uopData[0]), 128'(c));
    checkBits("wrap D across end", 128'(uopData[1]), 128'(d));
    applyStimulus(2'b00, 2'b01, 1'b0, '0, '0);
    checkBits("wrap D after pop", 128'(uopData[0]), 128'(d));
    applyStimulus(2'b00, 2'b01, 1'b0, '0, '0);
    checkOutput("wrap empty");

    // Flush at count 5 with a same-cycle push and pop.
    applyStimulus(2'b11, 2'b00, 1'b0, randUop(), randUop());
    applyStimulus(2'b11, 2'b00, 1'b0, randUop(), randUop());
    applyStimulus(2'b01, 2'b00, 1'b0, randUop(), randUop());
    checkOutput("pre flush");
    applyStimulus(2'b11, 2'b01, 1'b1, randUop(), randUop());
    checkOutput("flush");
    checkBits("flush empty", 128'(empty), 128'(1));
    e = randUop();
    applyStimulus(2'b01, 2'b00, 1'b0, e, randUop());
    checkOutput("post flush push");
    checkBits("post flush entry0", 128'(uopData[0]), 128'(e));

    // Random legal traffic with occasional flush and one asynchronous reset mid-burst.
    for (int i = 0; i < 10000; i++) begin
      int sz, maxPush, maxPop, np, no;
      logic [1:0] p, o;
      sz = modelQ.size();
      maxPush = (DEPTH - sz > 2) ? 2 : DEPTH - sz;
      maxPop = (sz > 2) ? 2 : sz;
      np = $urandom_range(maxPush, 0);
      no = $urandom_range(maxPop, 0);
      p = (np == 0) ? 2'b00 : (np == 1) ? 2'b01 : 2'b11;
      o = (no == 0) ? 2'b00 : (no == 1) ? 2'b01 : 2'b11;
      applyStimulus(p, o, ($urandom_range(63, 0) == 0), randUop(), randUop());
      checkOutput("random");
      if (i == 5000) begin
        push = 2'b11;
        pushData[0] = randUop();
        pushData[1] = randUop();
        #2;
        rst_n = 1'b0;
        #1;
        checkBits("async reset empty", 128'(empty), 128'(1));
        checkBits("async reset 1left_to_empty", 128'(oneLeftEmpty), 128'(1));
        checkBits("async reset full", 128'(full), 128'(0));
        checkBits("async reset 1left_to_full", 128'(oneLeftFull), 128'(0));
        checkBits("async reset data0", 128'(uopData[0]), 128'(0));
        checkBits("async reset data1", 128'(uopData[1]), 128'(0));
        push = 2'b00;
        modelQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("after async reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
